// File: rtl/cf_fuser_mc_pkg.sv
// Shared types and helpers for the cf_fuser_mc complementary filter.
// The build option CF_SAT_EN is consumed by cf_fuser_mc_blend_alu.
package cf_fuser_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTEG = 3'd1,
    S_BLEND = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Growth of the integrated estimate e' and of the accel-minus-estimate difference.
  localparam int E_GROW = 1;
  localparam int D_GROW = 2;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cf_fuser_mc_if.sv
// Frame-in / frame-out bus of cf_fuser_mc; channel 0 occupies the LSBs of every packed vector.
interface cf_fuser_mc_if #(
  parameter int NCH    = 3,
  parameter int DATA_W = 16,
  parameter int K_W    = 8
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a valid side holds its payload stable until that edge and never waits on ready to assert valid.
  logic                    valid_in;
  logic                    ready_in;
  logic [NCH*DATA_W-1:0]   gyro_in;
  logic [NCH*DATA_W-1:0]   accel_in;
  logic [K_W-1:0]          k_in;
  logic                    valid_out;
  logic                    ready_out;
  logic [NCH*DATA_W-1:0]   angle_out;

  modport master (
    output valid_in, gyro_in, accel_in, k_in, ready_out,
    input  ready_in, valid_out, angle_out
  );

  modport slave (
    input  valid_in, gyro_in, accel_in, k_in, ready_out,
    output ready_in, valid_out, angle_out
  );
endinterface

// File: rtl/cf_fuser_mc_blend_alu.sv
// Combinational blend step: angle = e' + (((accel - e') * k) >>> K_W), reduced to DATA_W.
// Reduction saturates when CF_SAT_EN is defined, otherwise wraps.
module cf_fuser_mc_blend_alu
  import cf_fuser_mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int K_W    = 8
) (
  input  logic signed [DATA_W:0]   e_pr,
  input  logic signed [DATA_W-1:0] accel,
  input  logic        [K_W-1:0]    k,
  output logic signed [DATA_W-1:0] result
);
  localparam int DW = DATA_W + D_GROW;
  localparam int PW = DW + K_W + 1;

  logic signed [DW-1:0] diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [PW-1:0] sum;

  assign diff    = DW'(accel) - DW'(e_pr);
  // k is unsigned: a zero MSB keeps the multiply signed without flipping large weights negative.
  assign prod    = diff * $signed({1'b0, k});
  assign shifted = prod >>> K_W;
  assign sum     = PW'(e_pr) + shifted;

`ifdef CF_SAT_EN
  always_comb begin
    result = sum[DATA_W-1:0];
    if (sum[PW-1:DATA_W-1] != {(PW-DATA_W+1){sum[PW-1]}}) begin
      result = sum[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[PW-1:DATA_W];
  assign result        = sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/cf_fuser_mc.sv
// Multi-channel complementary filter: one frame at a time, channels processed sequentially
// through a shared blend ALU. Optional saturation via CF_SAT_EN (see cf_fuser_mc_blend_alu).
module cf_fuser_mc
  import cf_fuser_mc_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int DATA_W   = 16,
  parameter int K_W      = 8,
  parameter int DT_SHIFT = 6
) (
  input  logic            clk,
  input  logic            rst,
  cf_fuser_mc_if.slave    bus,
  output state_t          dbg_state
);
  localparam int CH_W = ch_bits(NCH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  state_t state, next_state;

  logic [CH_W-1:0]                 ch;
  logic signed [DATA_W-1:0]        gyro_lat  [NCH];
  logic signed [DATA_W-1:0]        accel_lat [NCH];
  logic signed [DATA_W-1:0]        est       [NCH];
  logic signed [DATA_W-1:0]        angle_r   [NCH];
  logic [K_W-1:0]                  k_lat;
  logic signed [DATA_W+E_GROW-1:0] e_r;
  logic signed [DATA_W+E_GROW-1:0] e_next;
  logic signed [DATA_W-1:0]        gyro_sh;
  logic signed [DATA_W-1:0]        alu_res;
  logic signed [DATA_W-1:0]        res_r;
  logic                            valid_r;
  logic                            seeded;
  logic                            last_ch;

  assign bus.ready_in  = (state == S_IDLE) && !rst;
  assign bus.valid_out = valid_r;
  assign dbg_state     = state;
  assign last_ch       = (ch == LAST_CH);

  for (genvar i = 0; i < NCH; i++) begin : g_pack
    assign bus.angle_out[i*DATA_W +: DATA_W] = angle_r[i];
  end

  assign gyro_sh = gyro_lat[ch] >>> DT_SHIFT;
  assign e_next  = {est[ch][DATA_W-1], est[ch]} + {gyro_sh[DATA_W-1], gyro_sh};

  cf_fuser_mc_blend_alu #(
    .DATA_W (DATA_W),
    .K_W    (K_W)
  ) u_alu (
    .e_pr   (e_r),
    .accel  (accel_lat[ch]),
    .k      (k_lat),
    .result (alu_res)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.valid_in) next_state = S_INTEG;
      S_INTEG: next_state = S_BLEND;
      S_BLEND: next_state = S_WRITE;
      S_WRITE: next_state = last_ch ? S_DONE : S_INTEG;
      S_DONE:  if (bus.ready_out) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ch      <= '0;
      k_lat   <= '0;
      e_r     <= '0;
      res_r   <= '0;
      valid_r <= 1'b0;
      seeded  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        gyro_lat[i]  <= '0;
        accel_lat[i] <= '0;
        est[i]       <= '0;
        angle_r[i]   <= '0;
      end
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (bus.valid_in) begin
            ch    <= '0;
            k_lat <= bus.k_in;
            for (int i = 0; i < NCH; i++) begin
              gyro_lat[i]  <= bus.gyro_in[i*DATA_W +: DATA_W];
              accel_lat[i] <= bus.accel_in[i*DATA_W +: DATA_W];
            end
          end
        end
        S_INTEG: e_r <= e_next;
        // Until the first frame completes there is no estimate worth blending: take accel as-is.
        S_BLEND: res_r <= seeded ? alu_res : accel_lat[ch];
        S_WRITE: begin
          est[ch]     <= res_r;
          angle_r[ch] <= res_r;
          if (last_ch) valid_r <= 1'b1;
          else         ch      <= ch + 1'b1;
        end
        S_DONE: begin
          seeded <= 1'b1;
          if (bus.ready_out) valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cf_fuser_mc.sv
// Directed + randomized bench for cf_fuser_mc (NCH=2, DT_SHIFT=4) against a frame-level reference model.
module tb_cf_fuser_mc;
  import cf_fuser_mc_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int KW  = 8;
  localparam int DT  = 4;
  localparam int FW  = NCH * DW;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] exp_q[$];
  int            m_est [NCH];
  bit            m_seeded;

  cf_fuser_mc_if #(.NCH(NCH), .DATA_W(DW), .K_W(KW)) bus ();

  cf_fuser_mc #(
    .NCH      (NCH),
    .DATA_W   (DW),
    .K_W      (KW),
    .DT_SHIFT (DT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int reduce_ref(input longint s);
    longint lim;
    longint m;
    lim = longint'(1) << (DW - 1);
`ifdef CF_SAT_EN
    m = s;
    if (s > lim - 1) m = lim - 1;
    if (s < -lim)    m = -lim;
`else
    m = s & ((lim << 1) - 1);
    if (m >= lim) m = m - (lim << 1);
`endif
    return int'(m);
  endfunction

  function automatic logic [FW-1:0] model_frame(input logic [FW-1:0] g, input logic [FW-1:0] a,
                                                input int k);
    logic [FW-1:0] out;
    out = '0;
    for (int i = 0; i < NCH; i++) begin
      int     gi;
      int     ai;
      int     r;
      longint e;
      longint p;
      gi = int'($signed(g[i*DW +: DW]));
      ai = int'($signed(a[i*DW +: DW]));
      if (!m_seeded) begin
        r = ai;
      end else begin
        e = longint'(m_est[i]) + longint'(gi >>> DT);
        p = (longint'(ai) - e) * longint'(k);
        r = reduce_ref(e + (p >>> KW));
      end
      m_est[i] = r;
      out[i*DW +: DW] = DW'(r);
    end
    m_seeded = 1'b1;
    return out;
  endfunction

  function automatic logic [FW-1:0] rep(input logic [DW-1:0] v);
    logic [FW-1:0] o;
    for (int i = 0; i < NCH; i++) o[i*DW +: DW] = v;
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_angle_out", 64'(bus.angle_out), 64'd0);
    chk("rst_ready_in", 64'(bus.ready_in), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_in", 64'(bus.ready_in), 64'd1);
    for (int i = 0; i < NCH; i++) m_est[i] = 0;
    m_seeded = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [FW-1:0] g, input logic [FW-1:0] a, input int k);
    int n;
    n = 0;
    bus.gyro_in  = g;
    bus.accel_in = a;
    bus.k_in     = KW'(k);
    bus.valid_in = 1'b1;
    while (!bus.ready_in && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    exp_q.push_back(model_frame(g, a, k));
  endtask

  task automatic recv_frame(input int exp_lat, output logic [FW-1:0] got);
    int            n;
    logic [FW-1:0] exp;
    n = 0;
    if (exp_lat >= 0) chk("busy_ready_in", 64'(bus.ready_in), 64'd0);
    while (!bus.valid_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_lat >= 0) chk("latency", 64'(n), 64'(exp_lat));
    chk("valid_out_seen", 64'(bus.valid_out), 64'd1);
    chk("exp_q_size", 64'(exp_q.size()), 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    got = bus.angle_out;
    chk("angle", 64'(got), 64'(exp));
    bus.ready_out = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_out = 1'b0;
    chk("valid_drop", 64'(bus.valid_out), 64'd0);
  endtask

  task automatic run_frame(input logic [FW-1:0] g, input logic [FW-1:0] a, input int k,
                           output logic [FW-1:0] got);
    send_frame(g, a, k);
    // Accept edge counted as the first: valid_out is visible after the 3*NCH-th following edge.
    recv_frame(3 * NCH, got);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] got;
    logic [FW-1:0] snap;
    logic [FW-1:0] g;
    logic [FW-1:0] a;
    logic [DW-1:0] ovf_exp;
    int            k;
    int            n;
    bit            seen;

    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    bus.gyro_in   = '0;
    bus.accel_in  = '0;
    bus.k_in      = '0;

    do_reset(2);

    // Seeding: first frame passes accel through exactly.
    run_frame('0, {16'h2000, 16'h1000}, 26, got);
    chk("seed", 64'(got), 64'h2000_1000);

    // Pure gyro integration.
    do_reset(1);
    run_frame('0, '0, 0, got);
    for (int f = 1; f <= 3; f++) begin
      run_frame(rep(16'h0100), '0, 0, got);
      chk("gyro_only", 64'(got), 64'(rep(DW'(f * 16))));
    end

    // Half-weight blend toward accel.
    do_reset(1);
    run_frame('0, '0, 0, got);
    run_frame('0, rep(16'h0100), 128, got);
    chk("blend_1", 64'(got), 64'(rep(16'h0080)));
    run_frame('0, rep(16'h0100), 128, got);
    chk("blend_2", 64'(got), 64'(rep(16'h00C0)));

    // Backpressure in DONE with a competing frame offered.
    send_frame(rep(16'h0040), rep(16'h0200), 64);
    n = 0;
    while (!bus.valid_out && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_latency", 64'(n), 64'(3 * NCH));
    snap         = bus.angle_out;
    bus.gyro_in  = rep(16'h1234);
    bus.accel_in = rep(16'h4321);
    bus.k_in     = 8'd200;
    bus.valid_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_angle_stable", 64'(bus.angle_out), 64'(snap));
      chk("bp_valid_held", 64'(bus.valid_out), 64'd1);
      chk("bp_ready_in", 64'(bus.ready_in), 64'd0);
    end
    bus.valid_in = 1'b0;
    recv_frame(-1, got);
    run_frame(rep(16'hFFF0), rep(16'h0180), 32, got);

    // Overflow of the integrated estimate.
    do_reset(1);
    run_frame('0, rep(16'h7FF0), 0, got);
    run_frame(rep(16'h7FFF), '0, 0, got);
`ifdef CF_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h87EF;
`endif
    chk("overflow", 64'(got), 64'(rep(ovf_exp)));

    // Reset mid-frame: nothing from the aborted frame may appear.
    send_frame(rep(16'h0333), rep(16'h1111), 100);
    repeat (2) @(posedge clk);
    do_reset(1);
    seen = 1'b0;
    for (int c = 0; c < 3 * NCH + 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.valid_out) seen = 1'b1;
    end
    chk("no_partial_out", 64'(seen), 64'd0);

    // Randomized frames, weight extremes included.
    for (int i = 0; i < 24; i++) begin
      for (int c = 0; c < NCH; c++) begin
        g[c*DW +: DW] = DW'($urandom);
        a[c*DW +: DW] = DW'($urandom);
      end
      if (i % 6 == 0)      k = (1 << KW) - 1;
      else if (i % 6 == 1) k = 0;
      else                 k = int'($urandom_range(0, (1 << KW) - 1));
      run_frame(g, a, k, got);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
